reg_writeback_queue: RTL and testbench



---
 rtl/reg_writeback_queue.sv | 148 ++++++++++++++
 tb/tb_reg_writeback_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue.sv
// In-order writeback queue feeding the 16x16 register file from the ALU and memory-load paths.
// Exports a per-register pending mask for read-after-write hazard stalls in decode.
module reg_writeback_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mem_valid,
  input  logic [ADDR_W-1:0]            mem_rd,
  input  logic [DATA_W-1:0]            mem_data,
  output logic                         mem_ready,
  input  logic                         alu_valid,
  input  logic [ADDR_W-1:0]            alu_rd,
  input  logic [DATA_W-1:0]            alu_data,
  output logic                         alu_ready,
  input  logic                         wb_hold,
  output logic                         wb_en,
  output logic [ADDR_W-1:0]            wb_addr,
  output logic [DATA_W-1:0]            wb_data,
  output logic [15:0]                  pending,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [ADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wb_en_q, wb_en_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic [CNT_W-1:0]  free_s;
  logic              mem_ready_s, alu_ready_s;
  logic              enq_mem_s, enq_alu_s, pop_s;
  logic [PTR_W-1:0]  alu_ptr_s;
  logic [DEPTH-1:0]  entry_valid_s;
  logic [15:0]       pending_s;

  // Admission control from registered occupancy; a same-edge pop is deliberately not credited.
  always_comb begin
    free_s      = CNT_W'(DEPTH) - count_q;
    mem_ready_s = (free_s >= CNT_W'(1));
    alu_ready_s = (free_s >= CNT_W'(2)) || ((free_s >= CNT_W'(1)) && !mem_valid);
    enq_mem_s   = mem_valid && mem_ready_s;
    enq_alu_s   = alu_valid && alu_ready_s;
    pop_s       = (count_q != {CNT_W{1'b0}}) && !wb_hold;
  end

  // Next-state for storage, pointers, occupancy and the registered write port.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      addr_d[i] = addr_q[i];
      data_d[i] = data_q[i];
    end
    // The mem entry is older than the alu entry accepted on the same edge.
    alu_ptr_s = wr_ptr_q + {{(PTR_W-1){1'b0}}, enq_mem_s};
    if (enq_mem_s) begin
      addr_d[wr_ptr_q] = mem_rd;
      data_d[wr_ptr_q] = mem_data;
    end else begin
      addr_d[wr_ptr_q] = addr_q[wr_ptr_q];
      data_d[wr_ptr_q] = data_q[wr_ptr_q];
    end
    if (enq_alu_s) begin
      addr_d[alu_ptr_s] = alu_rd;
      data_d[alu_ptr_s] = alu_data;
    end else begin
      addr_d[alu_ptr_s] = addr_d[alu_ptr_s];
      data_d[alu_ptr_s] = data_d[alu_ptr_s];
    end
    wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, enq_mem_s} + {{(PTR_W-1){1'b0}}, enq_alu_s};
    rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, pop_s};
    count_d  = count_q + {{(CNT_W-1){1'b0}}, enq_mem_s} + {{(CNT_W-1){1'b0}}, enq_alu_s}
             - {{(CNT_W-1){1'b0}}, pop_s};
    wb_en_d  = pop_s;
    if (pop_s) begin
      wb_addr_d = addr_q[rd_ptr_q];
      wb_data_d = data_q[rd_ptr_q];
    end else begin
      wb_addr_d = wb_addr_q;
      wb_data_d = wb_data_q;
    end
  end

  // State register with synchronous reset that discards all queued entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= {ADDR_W{1'b0}};
        data_q[i] <= {DATA_W{1'b0}};
      end
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      wb_en_q   <= 1'b0;
      wb_addr_q <= {ADDR_W{1'b0}};
      wb_data_q <= {DATA_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_valid_s[i] = ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q);
    end
  end

  // Hazard mask covers live entries plus the write currently on the port.
  always_comb begin
    pending_s = 16'h0000;
    for (int i = 0; i < DEPTH; i++) begin
      pending_s[addr_q[i]] = pending_s[addr_q[i]] | entry_valid_s[i];
    end
    pending_s[wb_addr_q] = pending_s[wb_addr_q] | wb_en_q;
  end

  assign mem_ready = mem_ready_s;
  assign alu_ready = alu_ready_s;
  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign pending   = pending_s;
  assign count     = count_q;
  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == {CNT_W{1'b0}});

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Scoreboard bench for reg_writeback_queue: directed requests push expected writes,
// a negedge monitor pops and compares whenever the DUT drives wb_en.
module tb_reg_writeback_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, alu_valid, wb_hold;
  logic [3:0]  mem_rd, alu_rd;
  logic [15:0] mem_data, alu_data;
  logic        mem_ready, alu_ready, wb_en, full, empty;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data, pending;
  logic [2:0]  count;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } wb_t;

  wb_t sb[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  always #5 clk = ~clk;

  reg_writeback_queue #(.DATA_W(16), .ADDR_W(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .wb_hold(wb_hold), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .pending(pending), .count(count), .full(full), .empty(empty)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every driven register-file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rst === 1'b0 && wb_en === 1'b1) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_wb: got addr 0x%0h data 0x%0h expected no write at %0t",
                 wb_addr, wb_data, $time);
      end else begin
        wb_t e;
        e = sb.pop_front();
        chk("wb_addr", {28'h0, wb_addr}, {28'h0, e.a});
        chk("wb_data", {16'h0, wb_data}, {16'h0, e.d});
      end
    end
  end

  task automatic step(input logic mv, input logic [3:0] mrd, input logic [15:0] md,
                      input logic av, input logic [3:0] ard, input logic [15:0] ad,
                      input logic hold, input logic chk_rdy, input logic emr, input logic ear);
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    wb_hold   = hold;
    @(negedge clk);
    if (chk_rdy) begin
      chk("mem_ready", {31'h0, mem_ready}, {31'h0, emr});
      chk("alu_ready", {31'h0, alu_ready}, {31'h0, ear});
    end
    if (!rst) begin
      if (mv && emr) sb.push_back(wb_t'({mrd, md}));
      if (av && ear) sb.push_back(wb_t'({ard, ad}));
    end
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic idle(input logic hold);
    step(1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000, hold, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_idle_state(input string tag);
    chk({tag, "_count"},   {29'h0, count},   32'h0);
    chk({tag, "_wb_en"},   {31'h0, wb_en},   32'h0);
    chk({tag, "_pending"}, {16'h0, pending}, 32'h0);
    chk({tag, "_empty"},   {31'h0, empty},   32'h1);
    chk({tag, "_full"},    {31'h0, full},    32'h0);
  endtask

  logic [4:0] bp_ear = 5'b00011;
  logic [2:0] bp_cnt [5] = '{3'd2, 3'd3, 3'd3, 3'd3, 3'd3};

  initial begin
    // Reset with both requests asserted: nothing may be accepted.
    rst = 1'b1; wb_hold = 1'b0;
    mem_valid = 1'b1; mem_rd = 4'h2; mem_data = 16'hFFFF;
    alu_valid = 1'b1; alu_rd = 4'h3; alu_data = 16'hEEEE;
    repeat (2) begin
      @(posedge clk); #1;
      chk_idle_state("rst");
    end
    chk("rst_wb_addr", {28'h0, wb_addr}, 32'h0);
    chk("rst_wb_data", {16'h0, wb_data}, 32'h0);
    rst = 1'b0; mem_valid = 1'b0; alu_valid = 1'b0;
    @(posedge clk); #1;
    chk_idle_state("post_rst");

    // Single ALU write: two-edge latency, pending clears after the write.
    step(1'b0, 4'h0, 16'h0000, 1'b1, 4'h3, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("single_pending1", {16'h0, pending}, 32'h0008);
    chk("single_count1",   {29'h0, count},   32'h1);
    chk("single_wb_en1",   {31'h0, wb_en},   32'h0);
    idle(1'b0);
    chk("single_wb_en2",   {31'h0, wb_en},   32'h1);
    chk("single_pending2", {16'h0, pending}, 32'h0008);
    idle(1'b0);
    chk("single_pending3", {16'h0, pending}, 32'h0);
    chk("single_wb_en3",   {31'h0, wb_en},   32'h0);

    // Same destination from both sources: mem retires first.
    step(1'b1, 4'h5, 16'hAAAA, 1'b1, 4'h5, 16'h5555, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("same_count1",   {29'h0, count},   32'h2);
    chk("same_pending1", {16'h0, pending}, 32'h0020);
    idle(1'b0);
    chk("same_count2",   {29'h0, count},   32'h1);
    chk("same_pending2", {16'h0, pending}, 32'h0020);
    idle(1'b0);
    chk("same_wb_en3",   {31'h0, wb_en},   32'h1);
    chk("same_pending3", {16'h0, pending}, 32'h0020);
    idle(1'b0);
    chk("same_pending4", {16'h0, pending}, 32'h0);

    // Backpressure: both sources every cycle, count settles at 3.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'(i + 1), 16'hB000 | 16'(i + 1), 1'b1, 4'(i + 9), 16'hC000 | 16'(i + 1),
           1'b0, 1'b1, 1'b1, bp_ear[i]);
      chk("bp_count", {29'h0, count}, {29'h0, bp_cnt[i]});
    end
    repeat (5) idle(1'b0);
    chk("bp_empty",   {31'h0, empty},   32'h1);
    chk("bp_pending", {16'h0, pending}, 32'h0);

    // Hold until full, then release and drain in order.
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'h0, 16'h0000, 1'b1, 4'(i + 1), 16'h0011 * 16'(i + 1),
           1'b1, 1'b1, 1'b1, 1'b1);
    end
    step(1'b1, 4'h6, 16'hDEAD, 1'b1, 4'h7, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("hold_full",    {31'h0, full},    32'h1);
    chk("hold_count",   {29'h0, count},   32'h4);
    chk("hold_pending", {16'h0, pending}, 32'h001E);
    chk("hold_wb_en",   {31'h0, wb_en},   32'h0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      chk("drain_wb_en", {31'h0, wb_en}, 32'h1);
    end
    chk("drain_empty", {31'h0, empty}, 32'h1);
    idle(1'b0);
    chk("drain_pending", {16'h0, pending}, 32'h0);
    chk("drain_wb_en_off", {31'h0, wb_en}, 32'h0);

    // Reset mid-operation discards the three queued entries.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'h0, 16'h0000, 1'b1, 4'(i + 7), 16'h7000 + 16'(i), 1'b1, 1'b1, 1'b1, 1'b1);
    end
    chk("mid_count", {29'h0, count}, 32'h3);
    rst = 1'b1;
    idle(1'b0);
    rst = 1'b0;
    sb.delete();
    chk_idle_state("mid_rst");
    repeat (4) begin
      idle(1'b0);
      chk("mid_no_wb", {31'h0, wb_en}, 32'h0);
    end
    chk("sb_leftover", sb.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
